greenhouse_sequencer: RTL and testbench

GREENHOUSE_SEQUENCER -- requirements
Module: greenhouse_sequencer

---
 rtl/greenhouse_pkg.sv | 33 +++
 rtl/greenhouse_tick.sv | 24 ++
 rtl/greenhouse_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_greenhouse_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/greenhouse_pkg.sv
// Shared types and helpers for the greenhouse sequencer: pump states,
// sensor bit positions and the light-level lookup.
package greenhouse_pkg;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_RUN  = 2'd1,
        P_COOL = 2'd2
    } pump_state_t;

    localparam int SW_S1 = 0;
    localparam int SW_S2 = 1;
    localparam int SW_H  = 2;
    localparam int SW_T  = 3;
    localparam int SW_L  = 4;
    localparam int SW_M  = 5;

    localparam logic [3:0] MAX_LIGHTS = 4'd8;

    // Lockout forces the lights dark; otherwise levels 0..3 map to 2,4,6,8 lights.
    function automatic logic [3:0] level_target(input logic lockout, input logic [1:0] level);
        if (lockout)
            return 4'd0;
        return {1'b0, level, 1'b0} + 4'd2;
    endfunction

    function automatic logic [7:0] thermo(input logic [3:0] count);
        logic [8:0] one_hot;
        one_hot = 9'd1 << count;
        return 8'(one_hot - 9'd1);
    endfunction

endpackage

// File: rtl/greenhouse_tick.sv
// Scheduler tick: one-clk pulse every DIV clks, first pulse DIV clks after reset.
module greenhouse_tick #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(DIV + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (cnt == W'(DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    assign tick = (cnt == W'(DIV - 1));

endmodule

// File: rtl/greenhouse_sequencer.sv
// Greenhouse actuator sequencer: ramps growth lights toward a sensor-selected
// level, runs the pump with a max-on/cool-down cycle and holds the fan after demand.
module greenhouse_sequencer
    import greenhouse_pkg::*;
#(
    parameter int TICK_DIV    = 100000,
    parameter int STEP_TICKS  = 50,
    parameter int PUMP_MAX_ON = 5000,
    parameter int PUMP_COOL   = 10000,
    parameter int FAN_HOLD    = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sw,
    output logic [7:0] lights,
    output logic       fan,
    output logic       pump,
    output logic [3:0] light_count,
    output logic [1:0] pump_state,
    output logic       ramping
);
    localparam int STEP_W = $clog2(STEP_TICKS + 1);
    localparam int RUN_W  = $clog2(PUMP_MAX_ON + 1);
    localparam int COOL_W = $clog2(PUMP_COOL + 1);
    localparam int HOLD_W = $clog2(FAN_HOLD + 1);

    logic [5:0] sync1, sync2;
    logic       tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
        end
    end

    greenhouse_tick #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // ---------------- pump FSM ----------------
    pump_state_t       state, state_next;
    logic [RUN_W-1:0]  run_cnt, run_cnt_next;
    logic [COOL_W-1:0] cool_cnt, cool_cnt_next;
    logic              pump_start;

    assign pump_start = tick && (state == P_IDLE) && sync2[SW_M];

    always_comb begin
        state_next    = state;
        run_cnt_next  = run_cnt;
        cool_cnt_next = cool_cnt;
        if (tick) begin
            case (state)
                P_IDLE: begin
                    if (sync2[SW_M]) begin
                        state_next   = P_RUN;
                        run_cnt_next = '0;
                    end
                end
                P_RUN: begin
                    if (!sync2[SW_M] || (run_cnt + RUN_W'(1) == RUN_W'(PUMP_MAX_ON))) begin
                        state_next    = P_COOL;
                        cool_cnt_next = '0;
                    end else begin
                        run_cnt_next = run_cnt + RUN_W'(1);
                    end
                end
                P_COOL: begin
                    if (cool_cnt + COOL_W'(1) == COOL_W'(PUMP_COOL))
                        state_next = P_IDLE;
                    else
                        cool_cnt_next = cool_cnt + COOL_W'(1);
                end
                default: state_next = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= P_IDLE;
            run_cnt  <= '0;
            cool_cnt <= '0;
            pump     <= 1'b0;
        end else begin
            state    <= state_next;
            run_cnt  <= run_cnt_next;
            cool_cnt <= cool_cnt_next;
            pump     <= (state_next == P_RUN);
        end
    end

    assign pump_state = state;

    // ---------------- fan hold ----------------
    // A fan start that collides with a pump start is parked in fan_pend and
    // taken on the following tick, so both motors never inrush together.
    logic [HOLD_W-1:0] hold_cnt;
    logic              fan_pend;
    logic              demand, fan_start;

    assign demand    = sync2[SW_T] | sync2[SW_H] | fan_pend;
    assign fan_start = tick && demand && !fan && !pump_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fan      <= 1'b0;
            fan_pend <= 1'b0;
            hold_cnt <= '0;
        end else if (tick) begin
            if (demand) begin
                if (!fan && pump_start) begin
                    fan_pend <= 1'b1;
                end else begin
                    fan      <= 1'b1;
                    fan_pend <= 1'b0;
                    hold_cnt <= HOLD_W'(FAN_HOLD);
                end
            end else if (hold_cnt > HOLD_W'(1)) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
                fan      <= 1'b0;
            end
        end
    end

    // ---------------- light ramp ----------------
    logic [3:0]        target, target_q, count_next, count_step;
    logic [STEP_W-1:0] step_cnt, step_cnt_next;
    logic              step_defer, step_defer_next, step_due, inrush;

    assign target   = level_target(sync2[SW_L], {sync2[SW_S2], sync2[SW_S1]});
    assign inrush   = pump_start | fan_start;
    assign step_due = (step_cnt + STEP_W'(1) == STEP_W'(STEP_TICKS));

    always_comb begin
        if (light_count < target)
            count_step = (light_count == MAX_LIGHTS) ? MAX_LIGHTS : light_count + 4'd1;
        else
            count_step = (light_count == 4'd0) ? 4'd0 : light_count - 4'd1;
    end

    // A deferred step fires on the next tick unconditionally; it is never pushed twice.
    always_comb begin
        count_next      = light_count;
        step_cnt_next   = step_cnt;
        step_defer_next = step_defer;
        if (target != target_q) begin
            step_cnt_next   = '0;
            step_defer_next = 1'b0;
        end else if (tick) begin
            if (light_count == target) begin
                step_cnt_next   = '0;
                step_defer_next = 1'b0;
            end else if (step_defer || (step_due && !inrush)) begin
                count_next      = count_step;
                step_cnt_next   = '0;
                step_defer_next = 1'b0;
            end else if (step_due) begin
                step_cnt_next   = '0;
                step_defer_next = 1'b1;
            end else begin
                step_cnt_next = step_cnt + STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_q    <= '0;
            step_cnt    <= '0;
            step_defer  <= 1'b0;
            light_count <= '0;
            lights      <= '0;
            ramping     <= 1'b0;
        end else begin
            target_q    <= target;
            step_cnt    <= step_cnt_next;
            step_defer  <= step_defer_next;
            light_count <= count_next;
            lights      <= thermo(count_next);
            ramping     <= (count_next != target);
        end
    end

endmodule

// File: tb/tb_greenhouse_sequencer.sv
// Bench for greenhouse_sequencer: a tick-deadline model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_greenhouse_sequencer;
    localparam int TD    = 4;
    localparam int STEP  = 2;
    localparam int PMAX  = 5;
    localparam int PCOOL = 3;
    localparam int FHOLD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] sw  = 6'b0;
    logic [7:0] lights;
    logic       fan, pump, ramping;
    logic [3:0] light_count;
    logic [1:0] pump_state;

    int checks = 0;
    int failures = 0;

    greenhouse_sequencer #(
        .TICK_DIV(TD), .STEP_TICKS(STEP), .PUMP_MAX_ON(PMAX),
        .PUMP_COOL(PCOOL), .FAN_HOLD(FHOLD)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .lights(lights), .fan(fan), .pump(pump),
        .light_count(light_count), .pump_state(pump_state), .ramping(ramping)
    );

    always #5 clk = ~clk;

    // ---------------- model: absolute tick deadlines ----------------
    logic [5:0] m_s1, m_s2;
    int m_e, m_cnt, m_ptgt, m_step_at, m_pst, m_run_end, m_cool_end, m_off_at;
    bit m_defer, m_fan, m_fpend, m_ramp;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_e = 0; m_cnt = 0; m_ptgt = 0; m_step_at = 0;
        m_pst = 0; m_run_end = 0; m_cool_end = 0; m_off_at = 0;
        m_defer = 0; m_fan = 0; m_fpend = 0; m_ramp = 0;
    endtask

    task automatic model_step();
        logic [5:0] s;
        int tgt, tn;
        bit tk, pstart, dem, frise, inrush;
        s = m_s2; m_s2 = m_s1; m_s1 = sw;
        m_e++;
        tk = (m_e % TD == 0);
        tn = m_e / TD;
        tgt = s[4] ? 0 : 2 * (int'({s[1], s[0]}) + 1);
        pstart = tk && m_pst == 0 && s[5];
        dem = s[3] || s[2] || m_fpend;
        frise = tk && dem && !m_fan && !pstart;
        inrush = pstart || frise;
        if (tgt != m_ptgt) begin
            m_step_at = tn + STEP; m_defer = 0;
        end else if (tk) begin
            if (m_cnt == tgt) begin
                m_step_at = tn + STEP; m_defer = 0;
            end else if (m_defer || (tn == m_step_at && !inrush)) begin
                m_cnt = m_cnt + ((m_cnt < tgt) ? 1 : -1);
                m_step_at = tn + STEP; m_defer = 0;
            end else if (tn == m_step_at) begin
                m_defer = 1; m_step_at = tn + STEP;
            end
        end
        m_ptgt = tgt;
        if (tk) begin
            case (m_pst)
                0: if (s[5]) begin m_pst = 1; m_run_end = tn + PMAX; end
                1: if (!s[5] || tn == m_run_end) begin m_pst = 2; m_cool_end = tn + PCOOL; end
                default: if (tn == m_cool_end) m_pst = 0;
            endcase
            if (dem) begin
                if (!m_fan && pstart) m_fpend = 1;
                else begin m_fan = 1; m_fpend = 0; m_off_at = tn + FHOLD; end
            end else if (m_fan && tn >= m_off_at) begin
                m_fan = 0;
            end
        end
        m_ramp = (m_cnt != tgt);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("light_count", int'(light_count), m_cnt);
        check("lights", int'(lights), ((1 << m_cnt) - 1) & 255);
        check("ramping", int'(ramping), int'(m_ramp));
        check("fan", int'(fan), int'(m_fan));
        check("pump", int'(pump), int'(m_pst == 1));
        check("pump_state", int'(pump_state), m_pst);
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst) model_step();
            #1;
        end
    endtask

    task automatic set_sw(input logic [5:0] v);
        @(negedge clk);
        sw = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int fan_hi;
        #1 rst = 1'b0;
        model_reset();
        sw = 6'b000011;
        step(3);
        check("rst_lights", int'(lights), 0);
        check("rst_count", int'(light_count), 0);
        check("rst_fan", int'(fan), 0);
        check("rst_pump", int'(pump), 0);
        check("rst_pump_state", int'(pump_state), 0);
        check("rst_ramping", int'(ramping), 0);
        @(negedge clk) rst = 1'b1;

        // ramp up to full
        step(72);
        check("ramp_count", int'(light_count), 8);
        check("ramp_lights", int'(lights), 8'hFF);
        check("ramp_done", int'(ramping), 0);

        // lockout drops target to zero
        set_sw(6'b010011);
        step(80);
        check("drop_count", int'(light_count), 0);
        check("drop_lights", int'(lights), 0);

        // pump timeout with M held
        set_sw(6'b110000);
        n = 0;
        while (!pump && n < 40) begin step(1); n++; end
        check("pump_rise", int'(pump), 1);
        n = 0;
        while (pump && n < 100) begin step(1); n++; end
        check("pump_run_clks", n, PMAX * TD);
        n = 0;
        while (pump_state == 2'd2 && n < 100) begin step(1); n++; end
        check("pump_cool_clks", n, PCOOL * TD);
        n = 0;
        while (pump_state == 2'd0 && n < 100) begin step(1); n++; end
        check("pump_idle_clks", n, TD);
        set_sw(6'b010000);
        step(40);

        // fan hold after a one-tick T pulse
        set_sw(6'b011000);
        fan_hi = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 4) set_sw(6'b010000);
            step(1);
            if (fan) fan_hi++;
        end
        check("fan_hold_clks", fan_hi, FHOLD * TD);
        step(16);

        // inrush: pump start, fan start and light step all due on one tick
        while (m_e % TD != 0) step(1);
        set_sw(6'b000000);
        step(4);
        set_sw(6'b101000);
        step(4);
        check("inrush_pump", int'(pump), 1);
        check("inrush_fan_held", int'(fan), 0);
        check("inrush_step_held", int'(light_count), 0);
        step(4);
        check("inrush_fan_late", int'(fan), 1);
        check("inrush_step_late", int'(light_count), 1);

        // async reset mid-ramp with pump running
        step(2);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("arst_lights", int'(lights), 0);
        check("arst_count", int'(light_count), 0);
        check("arst_fan", int'(fan), 0);
        check("arst_pump", int'(pump), 0);
        check("arst_pump_state", int'(pump_state), 0);
        check("arst_ramping", int'(ramping), 0);
        step(3);
        @(negedge clk) rst = 1'b1;
        step(TD - 1);
        check("arst_no_early_tick", int'(pump), 0);
        step(1);
        check("arst_first_tick", int'(pump), 1);
        step(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
